// File: rtl/warp_issue_scheduler_pkg.sv
// Shared configuration for the warp issue scheduler: warp/instruction sizing,
// derived field widths and the controller state encoding.
package TauCfg;
   localparam int MAX_WARP = 4;
   localparam int N_INST   = 16;
   localparam int WID_BW   = $clog2(MAX_WARP);
   localparam int INST_BW  = $clog2(N_INST + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/warp_issue_scheduler_rr_priority_picker.sv
// Round-robin priority picker: returns the first set eligible bit found when
// scanning upward from rr, wrapping modulo N (N is a power of two).
module rr_priority_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0]         eligible,
   input  logic [$clog2(N)-1:0] rr,
   output logic                 found,
   output logic [$clog2(N)-1:0] idx
);
   localparam int WB = $clog2(N);

   logic [WB-1:0] pos;

   // Walk offsets from farthest to nearest so the nearest eligible slot wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = rr + WB'(k);
         if (eligible[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
   end
endmodule

// File: rtl/warp_issue_scheduler.sv
// Issues one instruction block across the launched warps in round-robin order,
// keeping at most one instruction in flight per warp until its commit returns.
module warp_issue_scheduler
   import TauCfg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               launch_rdy,
   output logic               launch_ack,
   input  logic [WID_BW:0]    i_n_warp,
   input  logic [INST_BW-1:0] i_pc_beg,
   input  logic [INST_BW-1:0] i_pc_end,
   output logic               inst_rdy,
   input  logic               inst_ack,
   output logic [INST_BW-1:0] o_pc,
   output logic [WID_BW-1:0]  o_warpid,
   input  logic               inst_commit_dval,
   input  logic [WID_BW-1:0]  i_commit_wid,
   output logic               done_rdy,
   input  logic               done_ack
);
   localparam logic [WID_BW:0] NW_MAX = (WID_BW + 1)'(MAX_WARP);

   state_t              state_q, state_d;
   logic [INST_BW-1:0]  end_q;
   logic [INST_BW-1:0]  pc_q [MAX_WARP];
   logic [MAX_WARP-1:0] active_q, pending_q, pending_d;
   logic [MAX_WARP-1:0] unfinished, eligible;
   logic [WID_BW-1:0]   rr_q, pick_idx, wid_out_q;
   logic [INST_BW-1:0]  pc_out_q;
   logic                pick_found, load_slot, issue, run_drained, inst_rdy_q;

   always_comb begin
      unfinished = '0;
      eligible   = '0;
      for (int w = 0; w < MAX_WARP; w++) begin
         unfinished[w] = active_q[w] && (pc_q[w] != end_q);
         eligible[w]   = unfinished[w] && !pending_q[w];
      end
   end

   rr_priority_picker #(
      .N (MAX_WARP)
   ) u_picker (
      .eligible (eligible),
      .rr       (rr_q),
      .found    (pick_found),
      .idx      (pick_idx)
   );

   // A new token may be loaded when the output register is empty or being drained.
   always_comb begin
      load_slot   = !inst_rdy_q || inst_ack;
      issue       = (state_q == RUN) && load_slot && pick_found;
      run_drained = (unfinished == '0) && (pending_q == '0) && !inst_rdy_q;

      pending_d = pending_q;
      if ((state_q == RUN) && inst_commit_dval) pending_d[i_commit_wid] = 1'b0;
      if (issue) pending_d[pick_idx] = 1'b1;

      state_d = state_q;
      case (state_q)
         IDLE:    if (launch_rdy) state_d = (i_pc_beg == i_pc_end) ? DONE : RUN;
         RUN:     if (run_drained) state_d = DONE;
         DONE:    if (done_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         end_q      <= '0;
         active_q   <= '0;
         pending_q  <= '0;
         rr_q       <= '0;
         inst_rdy_q <= 1'b0;
         pc_out_q   <= '0;
         wid_out_q  <= '0;
         for (int w = 0; w < MAX_WARP; w++) pc_q[w] <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         if ((state_q == IDLE) && launch_rdy) begin
            end_q     <= i_pc_end;
            rr_q      <= '0;
            pending_q <= '0;
            for (int w = 0; w < MAX_WARP; w++) begin
               pc_q[w]     <= i_pc_beg;
               active_q[w] <= ((WID_BW + 1)'(w) < i_n_warp);
            end
         end
         if ((state_q == RUN) && load_slot) begin
            inst_rdy_q <= pick_found;
            if (pick_found) begin
               pc_out_q       <= pc_q[pick_idx];
               wid_out_q      <= pick_idx;
               pc_q[pick_idx] <= pc_q[pick_idx] + INST_BW'(1);
               rr_q           <= pick_idx + WID_BW'(1);
            end
         end
      end
   end

   assign launch_ack = (state_q == IDLE) && launch_rdy;
   assign inst_rdy   = inst_rdy_q;
   assign o_pc       = pc_out_q;
   assign o_warpid   = wid_out_q;
   assign done_rdy   = (state_q == DONE);

   a_launch_nwarp : assert property (@(posedge i_clk) disable iff (i_rst)
      ((state_q == IDLE) && launch_rdy) |-> ((i_n_warp != '0) && (i_n_warp <= NW_MAX)))
      else $error("warp_issue_scheduler: launch with illegal warp count %0d", i_n_warp);

   a_stray_commit : assert property (@(posedge i_clk) disable iff (i_rst)
      ((state_q == RUN) && inst_commit_dval) |-> pending_q[i_commit_wid])
      else $warning("warp_issue_scheduler: ignored commit for non-pending warp %0d", i_commit_wid);
endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Directed bench for warp_issue_scheduler: hand-computed token sequences,
// back-pressure, full occupancy, simultaneous commit/ack and mid-run reset.
module tb_warp_issue_scheduler;
   import TauCfg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               launch_rdy = 1'b0;
   logic               launch_ack;
   logic [WID_BW:0]    n_warp = '0;
   logic [INST_BW-1:0] pc_beg = '0;
   logic [INST_BW-1:0] pc_end = '0;
   logic               inst_rdy;
   logic               inst_ack = 1'b0;
   logic [INST_BW-1:0] pc;
   logic [WID_BW-1:0]  warpid;
   logic               commit_dval = 1'b0;
   logic [WID_BW-1:0]  commit_wid = '0;
   logic               done_rdy;
   logic               done_ack = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   warp_issue_scheduler dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .launch_rdy       (launch_rdy),
      .launch_ack       (launch_ack),
      .i_n_warp         (n_warp),
      .i_pc_beg         (pc_beg),
      .i_pc_end         (pc_end),
      .inst_rdy         (inst_rdy),
      .inst_ack         (inst_ack),
      .o_pc             (pc),
      .o_warpid         (warpid),
      .inst_commit_dval (commit_dval),
      .i_commit_wid     (commit_wid),
      .done_rdy         (done_rdy),
      .done_ack         (done_ack)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_token(input string tag, input int exp_pc, input int exp_wid);
      check_val({tag, "_rdy"}, inst_rdy, 1);
      check_val({tag, "_pc"}, pc, exp_pc);
      check_val({tag, "_wid"}, warpid, exp_wid);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      launch_rdy = 1'b0;
      inst_ack = 1'b0;
      commit_dval = 1'b0;
      done_ack = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic do_launch(input int nw, input int beg, input int fin);
      n_warp = (WID_BW + 1)'(nw);
      pc_beg = INST_BW'(beg);
      pc_end = INST_BW'(fin);
      launch_rdy = 1'b1;
      #1;
      check_val("launch_ack", launch_ack, 1);
      tick();
      launch_rdy = 1'b0;
   endtask

   task automatic commit(input int wid);
      commit_dval = 1'b1;
      commit_wid = WID_BW'(wid);
   endtask

   initial begin
      // Reset and default launch
      #1;
      repeat (3) tick();
      check_val("rst_inst_rdy", inst_rdy, 0);
      check_val("rst_done_rdy", done_rdy, 0);
      check_val("rst_pc", pc, 0);
      check_val("rst_wid", warpid, 0);
      check_val("rst_launch_ack", launch_ack, 0);
      rst = 1'b0;
      inst_ack = 1'b1;
      do_launch(2, 3, 5);
      check_val("s1_first_gap", inst_rdy, 0);
      tick();  check_token("s1_t0", 3, 0);
      tick();  check_token("s1_t1", 3, 1);
      tick();  check_val("s1_stall", inst_rdy, 0);
      commit(0);
      tick();  check_val("s1_wait", inst_rdy, 0);
      commit(1);
      tick();  commit_dval = 1'b0; check_token("s1_t2", 4, 0);
      tick();  check_token("s1_t3", 4, 1);
      tick();  check_val("s1_drain", inst_rdy, 0); commit(0);
      tick();  check_val("s1_done_early0", done_rdy, 0); commit(1);
      tick();  commit_dval = 1'b0; check_val("s1_done_early1", done_rdy, 0);
      tick();  check_val("s1_done", done_rdy, 1);
      check_val("s1_done_no_inst", inst_rdy, 0);
      done_ack = 1'b1;
      tick();  done_ack = 1'b0;
      check_val("s1_done_clear", done_rdy, 0);

      // Empty range
      do_reset();
      do_launch(1, 7, 7);
      check_val("s2_done", done_rdy, 1);
      check_val("s2_no_inst", inst_rdy, 0);
      done_ack = 1'b1;
      tick();  done_ack = 1'b0;
      check_val("s2_done_clear", done_rdy, 0);
      check_val("s2_idle_inst", inst_rdy, 0);

      // Back-pressure
      do_reset();
      do_launch(2, 0, 2);
      tick();  check_token("s3_t0", 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick();  check_token("s3_hold", 0, 0);
      end
      inst_ack = 1'b1;
      tick();  check_token("s3_t1", 0, 1);

      // Full occupancy
      do_reset();
      inst_ack = 1'b1;
      do_launch(4, 0, 3);
      tick();  check_token("s4_t0", 0, 0);
      tick();  check_token("s4_t1", 0, 1);
      tick();  check_token("s4_t2", 0, 2);
      tick();  check_token("s4_t3", 0, 3);
      tick();  check_val("s4_full0", inst_rdy, 0);
      tick();  check_val("s4_full1", inst_rdy, 0);
      commit(2);
      tick();  commit_dval = 1'b0; check_val("s4_commit_edge", inst_rdy, 0);
      tick();  check_token("s4_reissue", 1, 2);

      // Simultaneous commit/ack, then stray commit
      do_reset();
      do_launch(2, 0, 4);
      tick();  check_token("s5_t0", 0, 0);
      inst_ack = 1'b1;
      tick();  check_token("s5_t1", 0, 1);
      tick();  check_val("s5_full", inst_rdy, 0);
      commit(0);
      tick();  commit_dval = 1'b0;
      tick();  check_token("s5_t2", 1, 0);
      inst_ack = 1'b1;
      commit(1);
      tick();  commit_dval = 1'b0; check_val("s5_same_cycle", inst_rdy, 0);
      inst_ack = 1'b0;
      tick();  check_token("s5_t3", 1, 1);
      commit(3);
      tick();  commit_dval = 1'b0; check_token("s5_stray_hold", 1, 1);
      inst_ack = 1'b1;
      tick();  check_val("s5_stray_nochg", inst_rdy, 0);
      commit(0);
      tick();  commit_dval = 1'b0;
      tick();  check_token("s5_t4", 2, 0);

      // Mid-run reset
      do_reset();
      inst_ack = 1'b1;
      do_launch(2, 0, 4);
      tick();  check_token("s6_t0", 0, 0);
      tick();  check_token("s6_t1", 0, 1);
      rst = 1'b1;
      tick();
      check_val("s6_rst_inst", inst_rdy, 0);
      check_val("s6_rst_pc", pc, 0);
      check_val("s6_rst_wid", warpid, 0);
      check_val("s6_rst_done", done_rdy, 0);
      rst = 1'b0;
      inst_ack = 1'b0;
      do_launch(1, 5, 6);
      tick();  check_token("s6_fresh", 5, 0);
      inst_ack = 1'b1;
      tick();  check_val("s6_drain", inst_rdy, 0); commit(0);
      tick();  commit_dval = 1'b0; check_val("s6_done_early", done_rdy, 0);
      tick();  check_val("s6_done", done_rdy, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/warp_issue_scheduler.md
Name: warp_issue_scheduler

Overview:
- Sequences one instruction block across up to MAX_WARP warps for the SIMD instruction port (inst rdy/ack plus inst_commit dval).
- Accepts a launch carrying warp count and PC range, then issues (pc, warp id) tokens in round-robin order.
- Each warp has at most one instruction in flight; the warp becomes eligible again only after its commit returns.
- Signals completion through a done handshake once every warp has finished its range and nothing is outstanding.

Parameters:
- MAX_WARP, 4, number of warp slots; power of two ≥2. WID_BW = $clog2(MAX_WARP).
- N_INST, 16, instruction memory depth. INST_BW = $clog2(N_INST+1).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- launch_rdy  in  1  launch request.
- launch_ack  out  1  launch accepted.
- i_n_warp  in  WID_BW+1  warps to run, 1..MAX_WARP.
- i_pc_beg  in  INST_BW  first PC.
- i_pc_end  in  INST_BW  PC one past the last.
- inst_rdy  out  1  issue token valid.
- inst_ack  in  1  SIMD accepts the token.
- o_pc  out  INST_BW  PC of the token.
- o_warpid  out  WID_BW  warp of the token.
- inst_commit_dval  in  1  one instruction retired.
- i_commit_wid  in  WID_BW  warp that retired.
- done_rdy  out  1  block complete.
- done_ack  in  1  completion consumed.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: state=IDLE; launch_ack, inst_rdy and done_rdy all 0; o_pc and o_warpid 0; per-warp pc, pending and active cleared; round-robin pointer rr=0.
- Handshakes are rdy/ack: a transfer happens on a cycle with rdy&&ack. A rdy output, once raised, is held with its payload stable until acked.
- States:
  - IDLE: launch_ack = launch_rdy (combinational). On the transfer:
    - latch end=i_pc_end;
    - for w < i_n_warp: pc[w]=i_pc_beg, active[w]=1;
    - for other warps: active=0;
    - rr=0;
    - next state is RUN, or DONE if i_pc_beg==i_pc_end.
  - RUN:
    - Eligible(w) = active[w] && !pending[w] && pc[w]!=end.
    - A load slot exists when !inst_rdy, or inst_rdy&&inst_ack.
    - In a load slot, pick the first eligible w scanning rr, rr+1, … mod MAX_WARP. Then, registered: o_pc=pc[w], o_warpid=w, inst_rdy=1, pc[w]+=1, pending[w]=1, rr=w+1 mod MAX_WARP.
    - No eligible warp in a load slot: inst_rdy drops to 0.
    - Back-to-back issue: one token per cycle while ack is held high.
    - Exit to DONE when no warp has pc!=end, no pending is set, and inst_rdy is 0, all evaluated on registered values.
  - DONE: done_rdy=1. On done_ack, go to IDLE; done_rdy drops the next cycle.
- Commit: inst_commit_dval clears pending[i_commit_wid] at the clock edge. The eligibility scan uses registered pending, so a committed warp is issuable from the next cycle.
  - Commit of a non-pending or inactive warp is ignored; flag it with a simulation assertion.
  - A commit and a selection of different warps in the same cycle are independent.
- Latency:
  - launch transfer → first inst_rdy: 2 cycles (state update, then load).
  - commit → reissue of that warp: ≥1 cycle.
  - last commit → done_rdy: 2 cycles.
- Width rules:
  - pc compares use equality only; pc never exceeds end.
  - rr wraps modulo MAX_WARP.
  - i_n_warp=0 or >MAX_WARP is illegal (assertion); behaviour is undefined.
- Commits outside RUN are ignored.
- Reset mid-operation: everything returns to reset values next cycle, and outstanding tokens are dropped. Upstream must reset together with this block.

Decomposition:
- Shared package (TauCfg) holds:
  - MAX_WARP and N_INST;
  - derived WID_BW and INST_BW;
  - the state enum {IDLE, RUN, DONE}.
- One sub-module, rr_priority_picker (parameter N): inputs eligible[N] and rr; outputs found and idx. Pure combinational.
- Everything else, including per-warp registers and the FSM, stays in this module.

Test Plan:
- Reset and default launch:
  - Reset held 3 cycles → all outputs 0.
  - Launch n_warp=2, pc 3..5, ack always 1, commit 2 cycles after each issue → tokens (3,w0),(3,w1),(4,w0),(4,w1); done_rdy after last commit +2.
- Empty range: launch pc_beg=pc_end=7 → no inst_rdy; done_rdy the cycle after the launch transfer; done_ack returns to IDLE.
- Back-pressure: hold inst_ack=0 for 5 cycles on token (0,w0) → o_pc and o_warpid stable, inst_rdy held; after ack the next token is (0,w1).
- Full occupancy: MAX_WARP=4, n_warp=4, withhold commits → exactly 4 tokens (w0..w3), then inst_rdy=0. Commit w2 → next token is w2 one cycle later.
- Simultaneous events: commit w1 in the same cycle w0 is acked → both handled, no lost pending clear. Stray commit of inactive w3 → no state change.
- Mid-run reset: assert i_rst while inst_rdy=1 and 2 warps pending → next cycle all outputs 0, state IDLE; a fresh launch runs normally.
